// File: rtl/montre_sysid_pkg.sv
// Shared types and constants for the montre system-ID boot checker.
package montre_sysid_pkg;

  localparam int DATA_W   = 32;
  localparam int RETRY_W  = 4;
  localparam int SETTLE_W = 8;
  localparam int LAT_W    = 3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    SETTLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/montre_sysid_if.sv
// Bus between the checker (master) and the sysid slave; readdata is combinational in the slave.
interface montre_sysid_if;
  import montre_sysid_pkg::*;

  logic              sysid_address;
  logic              sysid_read;
  logic [DATA_W-1:0] sysid_readdata;

  modport master (output sysid_address, output sysid_read, input  sysid_readdata);
  modport slave  (input  sysid_address, input  sysid_read, output sysid_readdata);
endinterface

// File: rtl/montre_sysid_delay_cnt.sv
// Loadable down-counter with a zero flag; shared by the settle and read-latency waits.
module montre_sysid_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/montre_sysid_checker.sv
// Boot-time sysid sequencer: reads ID and timestamp words, compares them with
// build-time values, retries on mismatch and reports pass/fail to the control logic.
module montre_sysid_checker
  import montre_sysid_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID   = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TS   = 32'd1665659394,
  parameter int unsigned       READ_LATENCY  = 1,
  parameter int unsigned       SETTLE_CYCLES = 4,
  parameter int unsigned       RETRY_MAX     = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  montre_sysid_if.master      sysid,
  output logic [DATA_W-1:0]   id_value,
  output logic [DATA_W-1:0]   ts_value,
  output logic                busy,
  output logic                done,
  output logic                id_ok,
  output logic                ts_ok,
  output logic [RETRY_W-1:0]  retries
);

  localparam logic [SETTLE_W-1:0] SETTLE_LEN = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] LAT_LEN    = SETTLE_W'(READ_LATENCY);
  localparam logic [RETRY_W-1:0]  RETRY_LIM  = RETRY_W'(RETRY_MAX);

  state_t               state, state_nxt;
  logic                 armed, armed_nxt;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 dly_load, dly_dec, dly_zero;
  logic [SETTLE_W-1:0]  dly_val, tmr_len;
  logic                 tmr_exp;
  logic                 cap_id, cap_ts, do_check, retry_inc, restart;
  logic                 id_match, ts_match;

  // A timed state's first cycle is spent loading the counter, so it loads len-2
  // and a length of 1 expires without touching the counter at all.
  assign tmr_len  = (state == SETTLE) ? SETTLE_LEN : LAT_LEN;
  assign tmr_exp  = armed ? dly_zero : (tmr_len == SETTLE_W'(1));
  assign id_match = (id_value == EXPECTED_ID);
  assign ts_match = (ts_value == EXPECTED_TS);

  montre_sysid_delay_cnt #(.W(SETTLE_W)) u_dly (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    dly_load  = 1'b0;
    dly_val   = tmr_len - SETTLE_W'(2);
    dly_dec   = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    do_check  = 1'b0;
    retry_inc = 1'b0;
    restart   = 1'b0;
    unique case (state)
      SETTLE, WAIT_ID, WAIT_TS: begin
        if (tmr_exp) begin
          armed_nxt = 1'b0;
          case (state)
            SETTLE:  state_nxt = RD_ID;
            WAIT_ID: begin cap_id = 1'b1; state_nxt = RD_TS; end
            default: begin cap_ts = 1'b1; state_nxt = CHECK; end
          endcase
        end else if (!armed) begin
          dly_load  = 1'b1;
          armed_nxt = 1'b1;
        end else begin
          dly_dec = 1'b1;
        end
      end
      RD_ID: begin
        if (READ_LATENCY == 0) begin cap_id = 1'b1; state_nxt = RD_TS; end
        else                         state_nxt = WAIT_ID;
      end
      RD_TS: begin
        if (READ_LATENCY == 0) begin cap_ts = 1'b1; state_nxt = CHECK; end
        else                         state_nxt = WAIT_TS;
      end
      CHECK: begin
        do_check = 1'b1;
        if (id_match && ts_match)        state_nxt = DONE;
        else if (retry_cnt < RETRY_LIM) begin
          retry_inc = 1'b1;
          state_nxt = SETTLE;
        end else                         state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SETTLE;
      armed     <= 1'b0;
      retry_cnt <= '0;
      id_value  <= '0;
      ts_value  <= '0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= armed_nxt;
      if (restart) begin
        retry_cnt <= '0;
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
      end else begin
        if (retry_inc) retry_cnt <= retry_cnt + RETRY_W'(1);
        if (do_check) begin
          id_ok <= id_match;
          ts_ok <= ts_match;
        end
      end
      if (cap_id) id_value <= sysid.sysid_readdata;
      if (cap_ts) ts_value <= sysid.sysid_readdata;
    end
  end

  // Address follows the state so it only moves on entry to RD_TS or SETTLE.
  assign sysid.sysid_address = (state inside {RD_TS, WAIT_TS, CHECK, DONE}) ? SYSID_ADDR_TS
                                                                            : SYSID_ADDR_ID;
  assign sysid.sysid_read    = (state == RD_ID) || (state == RD_TS);
  assign busy                = (state != DONE);
  assign done                = (state == DONE);
  assign retries             = retry_cnt;

endmodule
